dbg_log_serializer: RTL and testbench

- Receiver for the concatenated log stream that dbg_guv emits: one wide flit holding {TDATA, TKEEP, TLAST, TDEST, TID}.
- Splits each wide flit into a header word plus ceil(LOG_WIDTH/OUT_WIDTH) narrow body words on an OUT_WIDTH AXI-Stream.
- That narrow stream feeds the shared log return path toward the host.
- Each flit is tagged with the governor's address and a per-flit sequence number.

---
 rtl/dbg_log_serializer.sv | 126 ++++++++++++
 tb/tb_dbg_log_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_log_serializer.sv
// Splits one catted dbg_guv log flit into a header word plus NBODY narrow body words.
// The header is {GUV_ADDR, zeros, seq}; body words leave LSB-first and the final one carries TLAST.
module dbg_log_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 16,
  parameter int ID_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int GUV_ADDR   = 0,
  localparam int LOG_WIDTH = DATA_WIDTH + DATA_WIDTH/8 + 1 + DEST_WIDTH + ID_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LOG_WIDTH-1:0] log_catted_TDATA,
  input  logic                 log_catted_TVALID,
  output logic                 log_catted_TREADY,
  input  logic                 log_catted_TLAST,
  output logic [OUT_WIDTH-1:0] ser_TDATA,
  output logic                 ser_TVALID,
  input  logic                 ser_TREADY,
  output logic                 ser_TLAST
);

  localparam int NBODY = (LOG_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int SW    = (NBODY > 1) ? $clog2(NBODY) : 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t                     state, state_n;
  logic [NBODY*OUT_WIDTH-1:0] hold, hold_n;
  logic [SW-1:0]              widx, widx_n, widx_inc;
  logic [15:0]                seq, seq_n;
  logic [OUT_WIDTH-1:0]       data_n, hdr;
  logic                       valid_n, last_n;
  logic [OUT_WIDTH-1:0]       words [NBODY];
  logic                       in_hs, out_hs, last_hs;
  logic                       unused_tlast;

  // Every catted flit is self-contained, so the input TLAST carries no information.
  assign unused_tlast = log_catted_TLAST;

  assign out_hs            = ser_TVALID & ser_TREADY;
  assign last_hs           = out_hs & ser_TLAST;
  assign log_catted_TREADY = (state == IDLE) | last_hs;
  assign in_hs             = log_catted_TVALID & log_catted_TREADY;
  assign widx_inc          = widx + SW'(1);

  always_comb begin
    for (int unsigned k = 0; k < NBODY; k++) begin
      words[k] = hold[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    hdr                   = '0;
    hdr[OUT_WIDTH-1 -: 8] = 8'(GUV_ADDR);
    hdr[15:0]             = seq;
  end

  // widx names the body word currently on the output; a capture can only
  // happen from IDLE or on the last-word handshake, which gives zero-bubble flits.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    widx_n  = widx;
    seq_n   = seq;
    data_n  = ser_TDATA;
    valid_n = ser_TVALID;
    last_n  = ser_TLAST;
    if (in_hs) begin
      hold_n                  = '0;
      hold_n[LOG_WIDTH-1:0]   = log_catted_TDATA;
      seq_n                   = seq + 16'd1;
      data_n                  = hdr;
      valid_n                 = 1'b1;
      last_n                  = 1'b0;
      state_n                 = HDR;
    end else begin
      case (state)
        HDR: begin
          if (out_hs) begin
            data_n  = words[0];
            last_n  = (NBODY == 1);
            widx_n  = '0;
            state_n = BODY;
          end
        end
        BODY: begin
          if (out_hs) begin
            if (ser_TLAST) begin
              data_n  = '0;
              valid_n = 1'b0;
              last_n  = 1'b0;
              state_n = IDLE;
            end else begin
              widx_n = widx_inc;
              data_n = words[widx_inc];
              last_n = (widx_inc == SW'(NBODY - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      widx       <= '0;
      seq        <= '0;
      ser_TDATA  <= '0;
      ser_TVALID <= 1'b0;
      ser_TLAST  <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      widx       <= widx_n;
      seq        <= seq_n;
      ser_TDATA  <= data_n;
      ser_TVALID <= valid_n;
      ser_TLAST  <= last_n;
    end
  end

endmodule

// File: tb/tb_dbg_log_serializer.sv
// Directed bench for dbg_log_serializer at default widths with GUV_ADDR=0x05.
module tb_dbg_log_serializer;

  localparam int LW = 69;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [31:0]   ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_last;

  int total = 0;
  int bad   = 0;

  // {TDATA, TKEEP, TLAST, TDEST, TID}
  localparam logic [LW-1:0] FA = {32'hDEADBEEF, 4'hF, 1'b1, 16'h0012, 16'h0034};
  localparam logic [LW-1:0] FB = {32'h00000001, 4'h1, 1'b0, 16'hABCD, 16'h1234};

  always #5 clk = ~clk;

  dbg_log_serializer #(
    .DATA_WIDTH(32),
    .DEST_WIDTH(16),
    .ID_WIDTH  (16),
    .OUT_WIDTH (32),
    .GUV_ADDR  (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .log_catted_TDATA (in_data),
    .log_catted_TVALID(in_valid),
    .log_catted_TREADY(in_ready),
    .log_catted_TLAST (in_last),
    .ser_TDATA        (ser_data),
    .ser_TVALID       (ser_valid),
    .ser_TREADY       (ser_ready),
    .ser_TLAST        (ser_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic word(input string tag, input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, 32'(ser_valid), 32'd1);
    chk({tag, ".data"},  ser_data,       d);
    chk({tag, ".last"},  32'(ser_last),  32'(l));
  endtask

  task automatic idle_out(input string tag);
    chk({tag, ".valid"}, 32'(ser_valid), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    ser_ready = 1'b1;
    step();
    step();
    chk("rst.valid", 32'(ser_valid), 32'd0);
    chk("rst.data",  ser_data,       32'd0);
    chk("rst.last",  32'(ser_last),  32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);
    rst = 1'b0;

    // Single flit, free-running output
    in_data  = FA;
    in_valid = 1'b1;
    step();
    word("t1.hdr", 32'h05000000, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("t1.hdr.in_ready", 32'(in_ready), 32'd0);
    step(); word("t1.w0", 32'h00120034, 1'b0);
    step(); word("t1.w1", 32'hD5B7DDFF, 1'b0);
    step(); word("t1.w2", 32'h0000001B, 1'b1);
    step(); idle_out("t1.end");

    // Back-to-back flits after a fresh reset: headers carry seq 0 and 1
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_data  = FA;
    in_valid = 1'b1;
    step(); word("t2.a.hdr", 32'h05000000, 1'b0);
    in_data = FB;
    #1;
    chk("t2.a.hdr.in_ready", 32'(in_ready), 32'd0);
    step(); word("t2.a.w0", 32'h00120034, 1'b0);
    chk("t2.a.w0.in_ready", 32'(in_ready), 32'd0);
    step(); word("t2.a.w1", 32'hD5B7DDFF, 1'b0);
    step(); word("t2.a.w2", 32'h0000001B, 1'b1);
    chk("t2.a.w2.in_ready", 32'(in_ready), 32'd1);
    step(); word("t2.b.hdr", 32'h05000001, 1'b0);
    in_valid = 1'b0;
    step(); word("t2.b.w0", 32'hABCD1234, 1'b0);
    step(); word("t2.b.w1", 32'h00000022, 1'b0);
    step(); word("t2.b.w2", 32'h00000000, 1'b1);
    step(); idle_out("t2.end");

    // Output back-pressure: words hold steady, input stays blocked
    in_data  = FB;
    in_valid = 1'b1;
    step(); word("t3.hdr", 32'h05000002, 1'b0);
    ser_ready = 1'b0;
    #1;
    step(); word("t3.hdr.stall1", 32'h05000002, 1'b0);
    chk("t3.hdr.stall1.in_ready", 32'(in_ready), 32'd0);
    step(); word("t3.hdr.stall2", 32'h05000002, 1'b0);
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    step(); word("t3.w0", 32'hABCD1234, 1'b0);
    ser_ready = 1'b0;
    step(); word("t3.w0.stall", 32'hABCD1234, 1'b0);
    chk("t3.w0.stall.in_ready", 32'(in_ready), 32'd0);
    ser_ready = 1'b1;
    step(); word("t3.w1", 32'h00000022, 1'b0);
    ser_ready = 1'b0;
    step(); word("t3.w1.stall1", 32'h00000022, 1'b0);
    step(); word("t3.w1.stall2", 32'h00000022, 1'b0);
    ser_ready = 1'b1;
    step(); word("t3.w2", 32'h00000000, 1'b1);
    chk("t3.w2.in_ready", 32'(in_ready), 32'd1);
    step(); idle_out("t3.end");

    // Sequence wrap 0xFFFF -> 0x0000
    force dut.seq = 16'hFFFF;
    step();
    release dut.seq;
    in_data  = FB;
    in_valid = 1'b1;
    step(); word("t4.a.hdr", 32'h0500FFFF, 1'b0);
    step(); word("t4.a.w0", 32'hABCD1234, 1'b0);
    step(); word("t4.a.w1", 32'h00000022, 1'b0);
    step(); word("t4.a.w2", 32'h00000000, 1'b1);
    step(); word("t4.b.hdr", 32'h05000000, 1'b0);
    in_valid = 1'b0;
    step(); word("t4.b.w0", 32'hABCD1234, 1'b0);
    step(); word("t4.b.w1", 32'h00000022, 1'b0);
    step(); word("t4.b.w2", 32'h00000000, 1'b1);
    step(); idle_out("t4.end");

    // Reset during body word 1 discards the flit and restarts seq
    in_data  = FA;
    in_valid = 1'b1;
    step(); word("t5.hdr", 32'h05000001, 1'b0);
    in_valid = 1'b0;
    step(); word("t5.w0", 32'h00120034, 1'b0);
    step(); word("t5.w1", 32'hD5B7DDFF, 1'b0);
    rst = 1'b1;
    step();
    chk("t5.rst.valid", 32'(ser_valid), 32'd0);
    chk("t5.rst.data",  ser_data,       32'd0);
    chk("t5.rst.last",  32'(ser_last),  32'd0);
    chk("t5.rst.ready", 32'(in_ready),  32'd1);
    rst      = 1'b0;
    in_valid = 1'b1;
    step(); word("t5.next.hdr", 32'h05000000, 1'b0);
    in_valid = 1'b0;
    step(); word("t5.next.w0", 32'h00120034, 1'b0);
    step(); word("t5.next.w1", 32'hD5B7DDFF, 1'b0);
    step(); word("t5.next.w2", 32'h0000001B, 1'b1);
    step(); idle_out("t5.end");

    // Input held while output is blocked from idle
    ser_ready = 1'b0;
    in_data   = FB;
    in_valid  = 1'b1;
    step(); word("t6.hdr", 32'h05000001, 1'b0);
    chk("t6.hdr.in_ready", 32'(in_ready), 32'd0);
    step(); word("t6.hdr.hold1", 32'h05000001, 1'b0);
    chk("t6.hdr.hold1.in_ready", 32'(in_ready), 32'd0);
    step(); word("t6.hdr.hold2", 32'h05000001, 1'b0);
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    step(); word("t6.w0", 32'hABCD1234, 1'b0);
    step(); word("t6.w1", 32'h00000022, 1'b0);
    step(); word("t6.w2", 32'h00000000, 1'b1);
    step(); idle_out("t6.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
